// File: rtl/tdm_demux16_pkg.sv
// rtl/tdm_demux16_pkg.sv - defaults and slot helpers shared by the TDM demux modules
`include "tdm_demux_defs.vh"

package tdm_demux16_pkg;

    localparam int N_CH_DEFAULT = `TDM_DEMUX_N_CH;
    localparam int W_DEFAULT    = `TDM_DEMUX_W;
    localparam int SLOT_FIRST   = `TDM_SLOT_FIRST;

    // Width of a slot index for a frame of n slots.
    function automatic int sel_width(input int n);
        return `TDM_DEMUX_SEL_W(n);
    endfunction

    // Index of the final slot of a frame of n slots.
    function automatic int slot_last(input int n);
        return `TDM_SLOT_LAST(n);
    endfunction

endpackage

// File: rtl/tdm_demux_defs.vh
// rtl/tdm_demux_defs.vh - shared defaults and slot-index constants for the TDM demux
`ifndef TDM_DEMUX_DEFS_VH
`define TDM_DEMUX_DEFS_VH

`define TDM_DEMUX_N_CH        16
`define TDM_DEMUX_W           1
`define TDM_DEMUX_SEL_W(n)    $clog2(n)
`define TDM_SLOT_FIRST        0
`define TDM_SLOT_LAST(n)      ((n) - 1)

`endif

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - slot counter with sync restart and end-of-frame wrap detect
module tdm_slot_ctr
    import tdm_demux16_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load0,
    output logic [SEL_W-1:0] slot,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    localparam logic [SEL_W-1:0] FIRST = SEL_W'(SLOT_FIRST);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(slot_last(N_CH));

    logic [SEL_W-1:0] slot_q;

    // A sync forces the current capture to slot 0, so a sync on the last slot never wraps.
    assign idx  = load0 ? FIRST : slot_q;
    assign wrap = en && (idx == LAST);
    assign slot = slot_q;

    // Advance only on enabled cycles; gaps leave the slot pointer parked.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= FIRST;
        end else if (en) begin
            slot_q <= wrap ? FIRST : idx + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux16.sv
// rtl/tdm_demux16.sv - 1-to-N TDM demultiplexer; optional sync error pulse via TDM_DEMUX_SYNC_ERR_EN
module tdm_demux16
    import tdm_demux16_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT,
    parameter int W    = W_DEFAULT,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              e,
    input  logic              sync,
    input  logic [W-1:0]      d,
    output logic [SEL_W-1:0]  sel,
    output logic [N_CH*W-1:0] q,
    output logic              q_vld,
    output logic              sync_err
);

    logic              en;
    logic [SEL_W-1:0]  slot;
    logic [SEL_W-1:0]  idx;
    logic              wrap;
    logic [N_CH*W-1:0] shadow;
    logic [N_CH*W-1:0] frame_next;

    assign en  = ~e;
    assign sel = slot;

    tdm_slot_ctr #(
        .N_CH (N_CH)
    ) u_slot_ctr (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load0 (sync),
        .slot  (slot),
        .idx   (idx),
        .wrap  (wrap)
    );

    // Completed frame: the shadow with the last lane taken straight from the current slot data.
    always_comb begin
        frame_next = shadow;
        frame_next[(N_CH-1)*W +: W] = d;
    end

    // Capture each enabled slot into the shadow and publish the frame when the last slot lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            q      <= '0;
            q_vld  <= 1'b0;
        end else begin
            q_vld <= 1'b0;
            if (en) begin
                shadow[int'(idx)*W +: W] <= d;
                if (wrap) begin
                    q     <= frame_next;
                    q_vld <= 1'b1;
                end
            end
        end
    end

`ifdef TDM_DEMUX_SYNC_ERR_EN
    logic sync_err_q;

    // Flag a sync that lands anywhere other than slot 0 on an enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= en && sync && (slot != SEL_W'(SLOT_FIRST));
        end
    end

    assign sync_err = sync_err_q;
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux16.sv
// tb/tb_tdm_demux16.sv - table-driven bench for tdm_demux16 (N_CH=16, W=1)
module tb_tdm_demux16;

`ifdef TDM_DEMUX_SYNC_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        e;
        logic        sync;
        logic        d;
        logic [3:0]  sel;
        logic [15:0] q;
        logic        vld;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        e = 1'b1;
    logic        sync = 1'b0;
    logic [0:0]  d = 1'b0;
    logic [3:0]  sel;
    logic [15:0] q;
    logic        q_vld;
    logic        sync_err;

    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        vq[$];
    logic [15:0] held_q = '0;

    always #5 clk = ~clk;

    tdm_demux16 #(
        .N_CH (16),
        .W    (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .e        (e),
        .sync     (sync),
        .d        (d),
        .sel      (sel),
        .q        (q),
        .q_vld    (q_vld),
        .sync_err (sync_err)
    );

    task automatic push(input logic r, input logic en_n, input logic s, input logic dv,
                        input logic [3:0] esel, input logic [15:0] eq,
                        input logic evld, input logic eerr);
        vec_t v;
        v.rst = r; v.e = en_n; v.sync = s; v.d = dv;
        v.sel = esel; v.q = eq; v.vld = evld; v.err = eerr;
        vq.push_back(v);
    endtask

    // Full frame of 16 enabled slots; the frame appears on q after the last slot.
    task automatic frame(input logic [15:0] w, input logic sync_first, input logic err_first);
        for (int i = 0; i < 16; i++) begin
            push(1'b0, 1'b0, (i == 0) && sync_first, w[i], 4'((i + 1) % 16),
                 (i == 15) ? w : held_q, i == 15, (i == 0) && err_first);
        end
        held_q = w;
    endtask

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [15:0] w;
        int          vld_cyc[$];

        // 1. reset then frame A5C3, q_vld exactly one cycle
        push(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 16'h0, 1'b0, 1'b0);
        held_q = '0;
        frame(16'hA5C3, 1'b1, 1'b0);
        push(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'hA5C3, 1'b0, 1'b0);

        // 2. reset then e=1 for 500 cycles; sync toggling is ignored
        push(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
        held_q = '0;
        for (int i = 0; i < 500; i++)
            push(1'b0, 1'b1, 1'(i % 2), 1'b1, 4'd0, 16'h0, 1'b0, 1'b0);

        // 3. frame 00FF with a 3-cycle gap after slot 7
        w = 16'h00FF;
        for (int i = 0; i < 8; i++)
            push(1'b0, 1'b0, i == 0, w[i], 4'(i + 1), held_q, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            push(1'b0, 1'b1, 1'b1, 1'b0, 4'd8, held_q, 1'b0, 1'b0);
        for (int i = 8; i < 16; i++)
            push(1'b0, 1'b0, 1'b0, w[i], 4'((i + 1) % 16), (i == 15) ? w : held_q, i == 15, 1'b0);
        held_q = w;

        // 4a. realign: sync at slot 5, then frame 1234 starting on that sync
        for (int i = 0; i < 5; i++)
            push(1'b0, 1'b0, i == 0, 1'b1, 4'(i + 1), held_q, 1'b0, 1'b0);
        frame(16'h1234, 1'b1, ERR_ON);

        // 4b. sync on slot 15 restarts at 0 and emits no frame
        for (int i = 0; i < 15; i++)
            push(1'b0, 1'b0, i == 0, 1'b1, 4'(i + 1), held_q, 1'b0, 1'b0);
        frame(16'h0F0F, 1'b1, ERR_ON);

        // 5. back-to-back frames
        frame(16'hFFFF, 1'b1, 1'b0);
        frame(16'h0001, 1'b1, 1'b0);

        // 6. reset at slot 9 (overrides e and sync), then clean frame
        for (int i = 0; i < 9; i++)
            push(1'b0, 1'b0, i == 0, 1'b1, 4'(i + 1), held_q, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 16'h0, 1'b0, 1'b0);
        held_q = '0;
        frame(16'h5A5A, 1'b0, 1'b0);

        foreach (vq[k]) begin
            rst  = vq[k].rst;
            e    = vq[k].e;
            sync = vq[k].sync;
            d    = vq[k].d;
            @(posedge clk);
            #1;
            check("sel", k, 16'(sel), 16'(vq[k].sel));
            check("q", k, q, vq[k].q);
            check("q_vld", k, 16'(q_vld), 16'(vq[k].vld));
            check("sync_err", k, 16'(sync_err), 16'(vq[k].err));
        end

        // Hand-written: continuous frames 8001, q_vld spacing over a bounded window
        rst = 1'b1; e = 1'b1; sync = 1'b0; d = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        w = 16'h8001;
        for (int c = 0; c < 40; c++) begin
            e    = (c < 32) ? 1'b0 : 1'b1;
            sync = (c % 16) == 0;
            d    = w[c % 16];
            @(posedge clk);
            #1;
            if (q_vld) vld_cyc.push_back(c);
        end
        check("vld_count", 0, 16'(vld_cyc.size()), 16'd2);
        if (vld_cyc.size() == 2) begin
            check("vld_first", 0, 16'(vld_cyc[0]), 16'd15);
            check("vld_gap", 0, 16'(vld_cyc[1] - vld_cyc[0]), 16'd16);
        end
        check("q_8001", 0, q, 16'h8001);
        check("sel_end", 0, 16'(sel), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
